// File: rtl/hand_controller.sv
// hand_controller: sequences one blackjack hand. It clears the card buffer,
// fetches cards over a req/ack handshake, strobes each card into the buffer
// and applies the hit/stand/bust/21 rules.
// Optional feature macro: ACE_SOFT_EN (an ace may count as 11 while that
// keeps the total at or below 21).
module hand_controller #(
    parameter int MAX_CARDS  = 11,
    parameter int INIT_CARDS = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic       stand_i,
    output logic       card_req_o,
    input  logic       card_ack_i,
    input  logic [7:0] card_val_i,
    output logic       save_o,
    output logic [7:0] card_o,
    output logic       buf_rst_n_o,
    output logic [3:0] count_o,
    output logic [4:0] sum_o,
    output logic       busy_o,
    output logic       wait_o,
    output logic       done_o,
    output logic       bust_o,
    output logic       bj_o
);

    localparam logic [3:0] MAX_C  = 4'(MAX_CARDS);
    localparam logic [3:0] INIT_C = 4'(INIT_CARDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_REQ,
        S_SAVE,
        S_EVAL,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] card_q;
    logic [3:0] count_q;
    logic [4:0] hard_q;
    logic       bust_q;
    logic       bj_q;
    logic [4:0] eff_sum;

    // Only codes 1..13 are real cards; anything else is ignored in REQ.
    function automatic logic code_valid(input logic [7:0] code);
        return (code >= 8'd1) && (code <= 8'd13);
    endfunction

    // Hard weight: ace counts 1, face cards count 10, pips their own value.
    function automatic logic [4:0] card_weight(input logic [7:0] code);
        if (code == 8'd1)
            return 5'd1;
        else if (code >= 8'd11)
            return 5'd10;
        else
            return code[4:0];
    endfunction

`ifdef ACE_SOFT_EN
    logic ace_q;

    // One ace may be promoted to 11 when the total stays at or below 21.
    function automatic logic [4:0] soft_total(input logic [4:0] hard,
                                              input logic       ace);
        if (ace && (hard <= 5'd11))
            return hard + 5'd10;
        return hard;
    endfunction

    assign eff_sum = soft_total(hard_q, ace_q);
`else
    assign eff_sum = hard_q;
`endif

    // Hand sequencer: state, latched card, running count/sum and result flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            card_q  <= 8'd0;
            count_q <= 4'd0;
            hard_q  <= 5'd0;
            bust_q  <= 1'b0;
            bj_q    <= 1'b0;
`ifdef ACE_SOFT_EN
            ace_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i)
                        state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    count_q <= 4'd0;
                    hard_q  <= 5'd0;
                    bust_q  <= 1'b0;
                    bj_q    <= 1'b0;
`ifdef ACE_SOFT_EN
                    ace_q   <= 1'b0;
`endif
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    // Out-of-range codes leave the request up for another try.
                    if (card_ack_i && code_valid(card_val_i)) begin
                        card_q  <= card_val_i;
                        state_q <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    hard_q  <= hard_q + card_weight(card_q);
                    count_q <= count_q + 4'd1;
`ifdef ACE_SOFT_EN
                    if (card_q == 8'd1)
                        ace_q <= 1'b1;
`endif
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    // Bust is judged on the hard total; a soft total never exceeds 21.
                    if (hard_q > 5'd21) begin
                        bust_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (eff_sum == 5'd21) begin
                        bj_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else if (count_q == MAX_C) begin
                        state_q <= S_DONE;
                    end else if (count_q < INIT_C) begin
                        state_q <= S_REQ;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Stand takes priority over a simultaneous hit.
                    if (stand_i)
                        state_q <= S_DONE;
                    else if (hit_i)
                        state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register or taken from registers only.
    assign card_req_o  = (state_q == S_REQ);
    assign save_o      = (state_q == S_SAVE);
    assign buf_rst_n_o = (state_q != S_CLEAR);
    assign busy_o      = (state_q == S_CLEAR) || (state_q == S_REQ) ||
                         (state_q == S_SAVE)  || (state_q == S_EVAL);
    assign wait_o      = (state_q == S_WAIT);
    assign done_o      = (state_q == S_DONE);
    assign card_o      = card_q;
    assign count_o     = count_q;
    assign sum_o       = eff_sum;
    assign bust_o      = bust_q;
    assign bj_o        = bj_q;

endmodule

// File: doc/hand_controller.md
# hand_controller

Sequences one blackjack hand: clears the card buffer, fetches cards from the card source over a request/acknowledge handshake, and writes each card into the buffer with a one-cycle save pulse. Keeps the running card count and hand total, and applies the hit/stand/bust/21 rules. Sits between the player inputs, the deck/card source and the 11-entry card buffer, whose `save`, `data_in` and reset it drives.

## Interface
- `MAX_CARDS`, default 11: hand capacity; must equal the buffer depth.
- `INIT_CARDS`, default 2: cards dealt automatically after `start_i`.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin a new hand; sampled only in IDLE or DONE.
- `hit_i` in 1: player requests a card; sampled only in WAIT.
- `stand_i` in 1: player ends the hand; sampled only in WAIT.
- `card_req_o` out 1: request to the card source.
- `card_ack_i` in 1: card source presents `card_val_i`.
- `card_val_i` in 8: card code, 1 = ace, 2..10 = pips, 11..13 = J/Q/K.
- `save_o` out 1: one-cycle write strobe to the buffer's `save`.
- `card_o` out 8: raw card code to the buffer's `data_in`.
- `buf_rst_n_o` out 1: active-low buffer clear; low for exactly one cycle per hand.
- `count_o` out 4: cards in the hand.
- `sum_o` out 5: hand total.
- `busy_o` out 1: high in CLEAR, REQ, SAVE and EVAL.
- `wait_o` out 1: high in WAIT.
- `done_o` out 1: high in DONE.
- `bust_o` out 1: high when `sum_o` > 21; holds until the next CLEAR.
- `bj_o` out 1: high when `sum_o` == 21; holds until the next CLEAR.

## Operation
- States: IDLE, CLEAR, REQ, SAVE, EVAL, WAIT, DONE.
- IDLE or DONE, `start_i`=1 → CLEAR. CLEAR drives `buf_rst_n_o`=0 and zeroes the count, sum, `bust_o` and `bj_o`.
- CLEAR → REQ.
- REQ: `card_req_o`=1.
  - On `card_ack_i`=1 with a code in 1..13, latch the code → SAVE.
  - Codes 0 or >13 are ignored: stay in REQ with the request still high.
- SAVE: `save_o`=1 and `card_o` = latched code.
  - Card weight: 1 for an ace, 10 for codes 11..13, otherwise the code.
  - Sum += weight; count += 1.
  - → EVAL.
- EVAL, first matching rule wins:
  1. sum > 21 → DONE, `bust_o`=1.
  2. sum == 21 → DONE, `bj_o`=1.
  3. count == `MAX_CARDS` → DONE.
  4. count < `INIT_CARDS` → REQ.
  5. Otherwise → WAIT.
- WAIT: `stand_i` → DONE, else `hit_i` → REQ. When both are high, stand wins.
- DONE: holds `sum_o`, `count_o`, `bust_o` and `bj_o` until the next `start_i`.
- Arithmetic: the largest reachable hard sum is 20+10 = 30, so it fits in 5 bits and never wraps.
- `card_o` holds its last value outside SAVE.
- `start_i` is ignored in CLEAR, REQ, SAVE, EVAL and WAIT.

## Timing
- Reset (asynchronous, any state) → IDLE. Reset values:
  - `buf_rst_n_o`=1.
  - `card_req_o`, `save_o`, `busy_o`, `wait_o`, `done_o`, `bust_o`, `bj_o` = 0.
  - `card_o`=0, `count_o`=0, `sum_o`=0.
- The card source's own state is not reset by this block; a request cut off by reset is abandoned.
- Handshake:
  - The transfer happens on the rising edge where `card_req_o`=1 and `card_ack_i`=1.
  - `card_req_o` is low in the following cycle.
  - `card_ack_i` with `card_req_o`=0 is ignored.
- Latency, start to first save:
  - `start_i` seen at edge N → CLEAR in cycle N+1 → REQ from N+2.
  - Ack at edge M → `save_o` high in cycle M+1 → EVAL in M+2.
  - `count_o` and `sum_o` show the new values from cycle M+2.
- Minimum per card, ack in the first REQ cycle: REQ, SAVE, EVAL = 3 cycles.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.

## Configuration
- `ACE_SOFT_EN` defined:
  - The block tracks a soft-ace flag.
  - `sum_o` = hard sum + 10 when at least one ace is held and hard sum + 10 ≤ 21.
  - EVAL rules use this value.
  - `bust_o` is judged on the hard sum only.
- `ACE_SOFT_EN` undefined: an ace always weighs 1 and the soft-ace logic is absent.

## Test plan
- Reset mid-REQ with `card_req_o`=1 → all outputs at reset values in the same cycle, state IDLE.
- Start; cards 10, 5, stall ack 3 cycles on the first card → `buf_rst_n_o` low 1 cycle, 2 `save_o` pulses, `card_o` = 10 then 5, `count_o`=2, `sum_o`=15, `wait_o`=1.
- From WAIT with sum 15: hit, card 12 → `sum_o`=25, `bust_o`=1, `done_o`=1, `card_o`=12.
- Cards 0, 14, then 9 on successive acks → only 9 is saved, with a single `save_o` pulse.
- Aces and twos dealt with hit held high (`ACE_SOFT_EN` undefined) → stops at `count_o`=11 or at sum 21 with `bj_o`=1, whichever comes first; no 12th save.
- `ACE_SOFT_EN` defined, cards 1 and 13 → `sum_o`=21, `bj_o`=1, DONE after 2 cards; `hit_i` and `stand_i` high together in WAIT → DONE.
